// File: rtl/oper_sequencer_pkg.sv
// Shared definitions for the micro-operation sequencer: operation codes,
// FSM state encodings and the default per-operation timeout.
package oper_sequencer_pkg;

  localparam int OPER_CODE_LENGTH       = 4;
  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  typedef logic [OPER_CODE_LENGTH-1:0] oper_code_t;

  localparam oper_code_t OPER_NOP                = 4'h0;
  localparam oper_code_t OPER_READ_INST          = 4'h1;
  localparam oper_code_t OPER_READ_REGS          = 4'h2;
  localparam oper_code_t OPER_ENABLE_ALU_AND_RUN = 4'h3;
  localparam oper_code_t OPER_WRITE_REG          = 4'h4;
  localparam oper_code_t OPER_READ_MEM           = 4'h5;
  localparam oper_code_t OPER_WRITE_MEM          = 4'h6;
  localparam oper_code_t OPER_PUSH               = 4'h7;
  localparam oper_code_t OPER_POP                = 4'h8;
  localparam oper_code_t OPER_HALT               = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  function automatic logic state_is_busy(state_t s);
    return (s == S_FETCH) || (s == S_DECODE) || (s == S_EXEC);
  endfunction

endpackage

// File: rtl/oper_sequencer_if.sv
// Sequencer <-> decoder/datapath bundle. master = sequencer, slave = decoder
// plus datapath side. state_dbg exposes the sequencer FSM state.
interface oper_sequencer_if
  import oper_sequencer_pkg::*;
#(
  parameter int W = OPER_CODE_LENGTH
) ();

  // Handshake: OPER_CODE/STEP are stable while OPER_VALID=1; the operation
  // completes on a rising edge where OPER_VALID=1 and OPER_DONE=1. OPER_DONE
  // while OPER_VALID=0 has no effect.
  logic         START;
  logic [W-1:0] OPER_CODE_1;
  logic [W-1:0] OPER_CODE_2;
  logic [W-1:0] OPER_CODE_3;
  logic [W-1:0] OPER_CODE_4;
  logic         OPER_DONE;
  logic [W-1:0] OPER_CODE;
  logic         OPER_VALID;
  logic [1:0]   STEP;
  logic         BUSY;
  logic         HALTED;
  logic         RETIRE;
  logic         FAULT;
  state_t       state_dbg;

  modport master (
    input  START, OPER_CODE_1, OPER_CODE_2, OPER_CODE_3, OPER_CODE_4, OPER_DONE,
    output OPER_CODE, OPER_VALID, STEP, BUSY, HALTED, RETIRE, FAULT, state_dbg
  );

  modport slave (
    output START, OPER_CODE_1, OPER_CODE_2, OPER_CODE_3, OPER_CODE_4, OPER_DONE,
    input  OPER_CODE, OPER_VALID, STEP, BUSY, HALTED, RETIRE, FAULT, state_dbg
  );

endinterface

// File: rtl/oper_sequencer_watchdog.sv
// Per-operation timeout counter; only built when OPER_TIMEOUT_EN is defined.
// Restarts whenever no operation is pending or the current one completes.
`ifdef OPER_TIMEOUT_EN
module oper_sequencer_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic done,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!valid || done) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // The terminal cycle is the TIMEOUT_CYCLES-th waiting cycle; a DONE in that
  // same cycle still completes the operation normally.
  assign expired = valid && !done && (cnt_q == LAST);

endmodule
`endif

// File: rtl/oper_sequencer.sv
// Micro-operation sequencer: FETCH -> DECODE -> EXEC over up to four decoded
// slots, valid/done issue to the datapath. Optional timeout: OPER_TIMEOUT_EN.
module oper_sequencer
  import oper_sequencer_pkg::*;
#(
  parameter int          operation_code_length = OPER_CODE_LENGTH,
  parameter int unsigned TIMEOUT_CYCLES        = TIMEOUT_CYCLES_DEFAULT
) (
  input logic            CLK,
  input logic            RST_N,
  oper_sequencer_if.master bus
);

  localparam int W = operation_code_length;
  localparam logic [W-1:0] CODE_READ_INST = W'(OPER_READ_INST);
  localparam logic [W-1:0] CODE_HALT      = W'(OPER_HALT);

  state_t       state_q, state_d;
  logic [W-1:0] slot_q [4];
  logic [1:0]   step_q;
  logic         retire_q;
  logic         fault_q;

  logic [W-1:0] op_code;
  logic         op_valid;
  logic         busy;
  logic         halted;
  logic         timeout;

  logic [W-1:0] cur_op;
  logic         done_ev;
  logic         exec_done;
  logic         op_is_inst;
  logic         op_is_halt;
  logic         overflow;
  logic         advance;

  assign cur_op     = slot_q[step_q];
  assign done_ev    = op_valid && bus.OPER_DONE;
  assign exec_done  = (state_q == S_EXEC) && done_ev;
  assign op_is_inst = (cur_op == CODE_READ_INST);
  assign op_is_halt = (cur_op == CODE_HALT);
  assign overflow   = exec_done && !op_is_inst && !op_is_halt && (step_q == 2'd3);
  assign advance    = exec_done && !op_is_inst && !op_is_halt && (step_q != 2'd3);

`ifdef OPER_TIMEOUT_EN
  oper_sequencer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (CLK),
    .rst_n  (RST_N),
    .valid  (op_valid),
    .done   (bus.OPER_DONE),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.START) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (done_ev)      state_d = S_DECODE;
        else if (timeout) state_d = S_HALTED;
      end
      S_DECODE: begin
        // A leading HALT is never issued to the datapath.
        state_d = (bus.OPER_CODE_1 == CODE_HALT) ? S_HALTED : S_EXEC;
      end
      S_EXEC: begin
        if (exec_done) begin
          if (op_is_inst)        state_d = S_DECODE;
          else if (op_is_halt)   state_d = S_HALTED;
          else if (overflow)     state_d = S_HALTED;
        end else if (timeout) begin
          state_d = S_HALTED;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    op_code  = '0;
    op_valid = 1'b0;
    busy     = state_is_busy(state_q);
    halted   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        op_code  = CODE_READ_INST;
        op_valid = 1'b1;
      end
      S_EXEC: begin
        op_code  = cur_op;
        op_valid = 1'b1;
      end
      S_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  // Slots, step index, retire pulse and sticky fault
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 4; i++) slot_q[i] <= '0;
      step_q   <= 2'd0;
      retire_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      if (state_q == S_DECODE) begin
        slot_q[0] <= bus.OPER_CODE_1;
        slot_q[1] <= bus.OPER_CODE_2;
        slot_q[2] <= bus.OPER_CODE_3;
        slot_q[3] <= bus.OPER_CODE_4;
        step_q    <= 2'd0;
      end else if (advance) begin
        step_q <= step_q + 2'd1;
      end
      retire_q <= exec_done && op_is_inst;
      fault_q  <= fault_q | overflow | timeout;
    end
  end

  assign bus.OPER_CODE  = op_code;
  assign bus.OPER_VALID = op_valid;
  assign bus.STEP       = step_q;
  assign bus.BUSY       = busy;
  assign bus.HALTED     = halted;
  assign bus.RETIRE     = retire_q;
  assign bus.FAULT      = fault_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: doc/oper_sequencer.md
Name: oper_sequencer

Overview:
- Micro-operation sequencer for the CPU control path; steps the datapath through the up-to-four OPER_CODE_n slots produced by the opcode decoder for the current IR.
- Issues one operation code at a time to the datapath over a valid/done handshake.
- Retires the instruction when OPER_READ_INST completes, and stops permanently on OPER_HALT.
- Sits between the operation-code decoder, which is combinational from IR, and the datapath units: register file, ALU, memory, stack and PC.

Parameters:
- operation_code_length, default `operation_code_length: width of each operation code.
- TIMEOUT_CYCLES, default 16: cycles allowed per operation before a fault. Used only when OPER_TIMEOUT_EN is defined.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  reset; asynchronous, active-low.
- START  input  1  one-cycle pulse that begins execution; ignored outside IDLE.
- OPER_CODE_1..OPER_CODE_4  input  operation_code_length each  decoder outputs for the current IR.
- OPER_DONE  input  1  datapath completed the issued operation; sampled only while OPER_VALID=1.
- OPER_CODE  output  operation_code_length  operation currently issued.
- OPER_VALID  output  1  OPER_CODE is valid and executing.
- STEP  output  2  index (0..3) of the slot being issued.
- BUSY  output  1  high in FETCH, DECODE and EXEC.
- HALTED  output  1  core stopped.
- RETIRE  output  1  one-cycle pulse per retired instruction.
- FAULT  output  1  sequencing fault; sticky until reset.

Behaviour:
- Reset (asynchronous on RST_N=0; takes effect mid-operation):
  - state=IDLE, STEP=0, slot registers=0.
  - OPER_CODE=0, OPER_VALID=0, BUSY=0, HALTED=0, RETIRE=0, FAULT=0.
- States: IDLE, FETCH, DECODE, EXEC, HALTED.
- IDLE:
  - Outputs quiet.
  - START=1 -> FETCH.
- FETCH:
  - OPER_CODE=`OPER_READ_INST, OPER_VALID=1.
  - OPER_DONE=1 -> DECODE. IR is loaded by the datapath on this edge.
- DECODE (exactly 1 cycle, OPER_VALID=0):
  - Latch OPER_CODE_1..4 into slot[0..3]; STEP=0.
  - If slot[0] will be `OPER_HALT -> HALTED without issuing it; otherwise -> EXEC.
- EXEC:
  - OPER_CODE=slot[STEP], OPER_VALID=1, held stable until OPER_DONE.
  - OPER_DONE in the first valid cycle is legal, giving 1-cycle operations.
  - On OPER_DONE:
    - slot[STEP]==`OPER_READ_INST: RETIRE=1 next cycle -> DECODE.
    - slot[STEP]==`OPER_HALT: -> HALTED.
    - STEP==3 and neither of the above: FAULT=1 -> HALTED.
    - Otherwise: STEP<=STEP+1, stay in EXEC.
  - A slot holding `OPER_HALT at STEP>0 is issued like any other operation, then HALTED after its DONE.
- HALTED:
  - HALTED=1, OPER_VALID=0, BUSY=0.
  - Exits only on reset. START is ignored.
- Latency:
  - Instruction with N operations = 1 (DECODE) + sum of the operation latencies.
  - Minimum is N+1 cycles; an ALU instruction is 5 cycles with 1-cycle DONE.
- Decoder changes: changes to OPER_CODE_n after DECODE are ignored; the slots are frozen.
- OPER_DONE while OPER_VALID=0: ignored.
- STEP does not wrap; overflow is impossible because STEP==3 always exits EXEC.

Optional Feature:
- Macro OPER_TIMEOUT_EN.
- When defined:
  - A per-operation counter clears at each new issue and increments while OPER_VALID=1 and OPER_DONE=0.
  - On reaching TIMEOUT_CYCLES: FAULT=1 -> HALTED.
  - DONE arriving in the same cycle as the terminal count wins.
- When undefined:
  - No counter; waits indefinitely.
  - FAULT is driven only by the slot-overflow fault.

Decomposition:
- Shared header oper_sequencer_states.h: state encodings (IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALTED=4) and the TIMEOUT_CYCLES default.
- Operation codes remain in operation_codes_list.h.
- One natural sub-module: oper_watchdog, the timeout counter, instantiated only under OPER_TIMEOUT_EN.

Test Plan:
- Reset then START, datapath DONE=1 every valid cycle, decoder giving READ_REGS/ENABLE_ALU_AND_RUN/WRITE_REG/READ_INST:
  - FETCH in cycle 1, DECODE in cycle 2, the four operations in cycles 3-6.
  - RETIRE pulses in cycle 7, then DECODE.
- MOV sequence (READ_REGS/WRITE_REG/READ_INST) with DONE delayed 3 cycles on WRITE_REG:
  - OPER_CODE held stable, STEP=1 for 4 cycles.
  - RETIRE after the READ_INST DONE.
- slot[0]=OPER_HALT:
  - No OPER_VALID after DECODE.
  - HALTED=1, BUSY=0; a later START has no effect.
- All four slots set to READ_REGS (no READ_INST):
  - FAULT=1 and HALTED=1 after the 4th DONE.
- RST_N asserted low mid-EXEC (STEP=2, waiting for DONE):
  - All outputs 0 immediately (asynchronous); IDLE after release.
- OPER_TIMEOUT_EN defined, DONE never asserted:
  - FAULT=1 after 16 valid cycles.
  - OPER_TIMEOUT_EN undefined: still waiting in EXEC after 100 cycles.
